fifo_ma_reader: RTL and testbench
=================================

# fifo_ma_reader

Read-side consumer for the DSP block's sample FIFO. It pops samples from the FIFO's read port with a first-word-fall-through handshake and computes an N-point moving average over the last N samples. Results go downstream on a valid/ready interface. It runs entirely in the FIFO read clock domain and is the counterpart of the FIFO write-side producer.

## Interface
- D_SIZE, 8, sample and output width in bits (unsigned).
- WIN_LOG2, 2, log2 of the window length; N = 2^WIN_LOG2.
- i_clk  in  1  read-domain clock; connects to the FIFO read clock.
- i_rstn  in  1  reset, asynchronous and active-low.
- i_empty  in  1  FIFO empty flag.
- i_r_data  in  D_SIZE  FIFO read data; valid whenever i_empty is low (fall-through).
- o_r_inc  out  1  FIFO read enable; one pop per high cycle.
- i_clear  in  1  synchronous flush of the averaging history.
- o_data  out  D_SIZE  moving-average result.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts o_data.
- o_primed  out  1  at least N samples have entered the window since reset or clear.

## Operation
- FSM states: IDLE, POP, CALC, OUT.
  - IDLE -> POP when i_empty is low.
  - POP -> CALC unconditionally. o_r_inc = 1 in POP only, decoded from the state register. The sample register captures i_r_data.
  - CALC -> OUT. Updates sum <= sum + sample - tap[N-1], shifts the tap line (tap[0] <= sample), and increments the fill counter, saturating at N.
  - OUT: o_valid = 1. On i_ready = 1, go to POP if i_empty is low, else to IDLE.
- History (taps, sum) resets to zero. Output is produced from the first sample onward, with missing history counted as zero.
- Sum width is D_SIZE+WIN_LOG2 and cannot overflow.
- o_data = sum[D_SIZE+WIN_LOG2-1 : WIN_LOG2], i.e. a truncating divide by N. It is driven from the sum register and is stable throughout OUT.
- o_primed = (fill counter == N).
- i_clear has priority in every state.
  - At the next edge: taps, sum, and fill counter go to 0 and the state goes to IDLE.
  - If i_clear is asserted in POP, the pop still occurs and the popped sample is discarded.
- o_r_inc is never high while in IDLE, CALC, or OUT. A pop is only issued from a state entered after sampling i_empty low. This block is the sole reader, so empty cannot reassert before the pop.

## Timing
- Reset values: o_r_inc 0, o_valid 0, o_data 0, o_primed 0, state IDLE, all taps and sum 0.
- Latency, counting edge k as the first edge with i_empty low in IDLE:
  - POP (o_r_inc high) during cycle k+1.
  - CALC during cycle k+2.
  - o_valid high from edge k+3.
- Back-to-back throughput with i_ready held high and FIFO non-empty: one sample per 3 cycles (OUT -> POP -> CALC -> OUT).
- Backpressure: while i_ready = 0 in OUT, o_valid, o_data, and o_primed hold, and no pop occurs.
- o_valid drops in the cycle after the accepting edge.
- Asynchronous reset mid-operation:
  - All outputs go to reset values immediately.
  - A pop asserted in that cycle is abandoned. o_r_inc falls with reset, and the FIFO owns whether the pop commits.
- i_clear and i_ready both high in OUT: clear wins. The state goes to IDLE and the result counts as consumed.

## Structure
- Shared package ma_pkg holds:
  - state encoding localparams (ST_IDLE, ST_POP, ST_CALC, ST_OUT);
  - default D_SIZE and WIN_LOG2.
- Sub-module ma_tap_line(D_SIZE, WIN_LOG2) holds:
  - the N-entry shift register, with a shift enable and a synchronous clear;
  - the oldest-tap output.
- The FSM, sum, and fill counter live in fifo_ma_reader.

## Test plan
All scenarios use N = 4 and D_SIZE = 8.
- Reset: assert i_rstn = 0 with the FIFO model holding data -> all outputs 0, and no o_r_inc for the whole reset.
- Basic stream: push 10, 20, 30, 40, 50 with i_ready = 1 -> outputs 2, 7, 15, 25, 35. o_primed rises with the 4th output. Exactly 5 single-cycle o_r_inc pulses, 3 cycles apart.
- Backpressure: hold i_ready = 0 for 5 cycles on output 15 -> o_valid and o_data = 15 are stable and no o_r_inc occurs. After release, the next pop comes the following cycle.
- Full-scale: push four 255s -> final output 255, sum 1020, no wrap.
- Clear in POP: after 10, 20, 30, 40, assert i_clear during the next POP (sample 99), then push 8 -> 99 is never output, next output is 2, and o_primed is 0.
- Underflow and reset mid-op:
  - Let the FIFO go empty mid-stream -> the FSM idles with o_r_inc never high while i_empty is high, and resumes when data returns.
  - Assert async reset while in OUT -> o_valid and o_data go to 0 within the same cycle.

Source files
------------

// File: rtl/ma_pkg.sv
// Shared definitions for the FIFO read-side moving-average consumer:
// default widths and the FSM state encoding.
package ma_pkg;

   localparam int D_SIZE_DEF   = 8;
   localparam int WIN_LOG2_DEF = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_POP  = 2'd1;
   localparam logic [1:0] ST_CALC = 2'd2;
   localparam logic [1:0] ST_OUT  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_POP  = ST_POP,
      S_CALC = ST_CALC,
      S_OUT  = ST_OUT
   } state_t;

endpackage

// File: rtl/ma_tap_line.sv
// N-entry sample history for the moving average; tap[0] is the newest sample
// and o_oldest is the sample that leaves the window on the next shift.
module ma_tap_line
   import ma_pkg::*;
#(
   parameter int D_SIZE   = D_SIZE_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_shift,
   input  logic              i_clear,
   input  logic [D_SIZE-1:0] i_data,
   output logic [D_SIZE-1:0] o_oldest
);

   localparam int N = 1 << WIN_LOG2;

   logic [D_SIZE-1:0] taps [N];

   // NOTE: the taps carry a reset because missing history must read as zero.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < N; i++) taps[i] <= '0;
      end else if (i_clear) begin
         for (int i = 0; i < N; i++) taps[i] <= '0;
      end else if (i_shift) begin
         taps[0] <= i_data;
         for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
      end
   end

   assign o_oldest = taps[N-1];

endmodule

// File: rtl/fifo_ma_reader.sv
// Pops samples from a fall-through FIFO, keeps a running N-point sum and
// presents the truncated average on a valid/ready output.
module fifo_ma_reader
   import ma_pkg::*;
#(
   parameter int D_SIZE   = D_SIZE_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_empty,
   input  logic [D_SIZE-1:0] i_r_data,
   output logic              o_r_inc,
   input  logic              i_clear,
   output logic [D_SIZE-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_primed
);

   localparam int SW = D_SIZE + WIN_LOG2;
   localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2+1)'(1 << WIN_LOG2);

   state_t              state, state_nx;
   logic [D_SIZE-1:0]   sample;
   logic [D_SIZE-1:0]   oldest;
   logic [SW-1:0]       sum;
   logic [WIN_LOG2:0]   fill;
   logic                calc_en;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= S_IDLE;
      else         state <= state_nx;
   end

   // NOTE: every output of this block is given a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      o_r_inc  = 1'b0;
      o_valid  = 1'b0;
      calc_en  = 1'b0;
      case (state)
         S_IDLE: if (!i_empty) state_nx = S_POP;
         S_POP: begin
            o_r_inc  = 1'b1;
            state_nx = S_CALC;
         end
         S_CALC: begin
            calc_en  = !i_clear;
            state_nx = S_OUT;
         end
         S_OUT: begin
            o_valid = 1'b1;
            if (i_ready) state_nx = i_empty ? S_IDLE : S_POP;
         end
         default: state_nx = S_IDLE;
      endcase
      // A flush overrides any transition; a pop already in flight still completes.
      if (i_clear) state_nx = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)              sample <= '0;
      else if (state == S_POP)  sample <= i_r_data;
   end

   // Sum holds exactly the last N samples, so SW bits never wrap even though
   // the intermediate add/subtract is done modulo 2^SW.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         sum  <= '0;
         fill <= '0;
      end else if (i_clear) begin
         sum  <= '0;
         fill <= '0;
      end else if (calc_en) begin
         sum  <= sum + SW'(sample) - SW'(oldest);
         if (fill != FILL_FULL) fill <= fill + 1'b1;
      end
   end

   ma_tap_line #(
      .D_SIZE   (D_SIZE),
      .WIN_LOG2 (WIN_LOG2)
   ) u_tap_line (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_shift  (calc_en),
      .i_clear  (i_clear),
      .i_data   (sample),
      .o_oldest (oldest)
   );

   assign o_data   = sum[SW-1:WIN_LOG2];
   assign o_primed = (fill == FILL_FULL);

endmodule

// File: tb/tb_fifo_ma_reader.sv
// Directed bench for fifo_ma_reader with a fall-through FIFO model; all
// stimulus and sampling happen on the falling clock edge.
module tb_fifo_ma_reader;

   logic       i_clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic       i_empty = 1'b1;
   logic [7:0] i_r_data = 8'h00;
   logic       o_r_inc;
   logic       i_clear = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready = 1'b0;
   logic       o_primed;

   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         pops = 0;
   int         bad_pop = 0;
   bit         pop_pend = 0;
   logic [7:0] q[$];

   fifo_ma_reader #(.D_SIZE(8), .WIN_LOG2(2)) dut (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_empty  (i_empty),
      .i_r_data (i_r_data),
      .o_r_inc  (o_r_inc),
      .i_clear  (i_clear),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_primed (o_primed)
   );

   always #5 i_clk = ~i_clk;

   task automatic sync_fifo();
      i_empty  = (q.size() == 0);
      i_r_data = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] v);
      q.push_back(v);
      sync_fifo();
   endtask

   // Advance to the next falling edge, commit a pop issued in the previous
   // cycle, and log this cycle's pop request.
   task automatic tick();
      @(negedge i_clk);
      cyc++;
      if (pop_pend && i_rstn && q.size() != 0) void'(q.pop_front());
      pop_pend = 0;
      sync_fifo();
      if (o_r_inc === 1'b1) begin
         pops++;
         pop_pend = 1;
         if (i_empty) bad_pop++;
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (o_valid !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      n_checks++;
      if (o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: o_valid=%b required 1", name, o_valid);
      end
   endtask

   task automatic expect_out(input logic [7:0] exp, input logic exp_p, input string name);
      wait_valid(name);
      n_checks++;
      if (o_data !== exp) begin
         n_fail++;
         $display("FAIL %s data: got %0d required %0d", name, o_data, exp);
      end
      n_checks++;
      if (o_primed !== exp_p) begin
         n_fail++;
         $display("FAIL %s primed: got %b required %b", name, o_primed, exp_p);
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
   endtask

   task automatic test_reset();
      int inc_seen = 0;
      i_rstn = 1'b0;
      push(8'd10); push(8'd20); push(8'd30); push(8'd40); push(8'd50);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_r_inc !== 1'b0) inc_seen++;
      end
      n_checks++;
      if (inc_seen != 0) begin
         n_fail++;
         $display("FAIL reset_no_pop: got %0d pop cycles required 0", inc_seen);
      end
      n_checks++;
      if ({o_r_inc, o_valid, o_primed, o_data} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: r_inc=%b valid=%b primed=%b data=%0d required all 0",
                  o_r_inc, o_valid, o_primed, o_data);
      end
      i_rstn = 1'b1;
   endtask

   task automatic test_basic_stream();
      logic [7:0] exp_d [5] = '{8'd2, 8'd7, 8'd15, 8'd25, 8'd35};
      logic       exp_p [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int pop_cyc[$];
      int out_cyc[$];
      logic [7:0] got_d[$];
      logic got_p[$];
      int start;
      i_ready = 1'b1;
      start = cyc;
      for (int i = 0; i < 22; i++) begin
         tick();
         if (o_r_inc === 1'b1) pop_cyc.push_back(cyc);
         if (o_valid === 1'b1) begin
            out_cyc.push_back(cyc);
            got_d.push_back(o_data);
            got_p.push_back(o_primed);
         end
      end
      i_ready = 1'b0;
      n_checks++;
      if (pop_cyc.size() != 5 || out_cyc.size() != 5) begin
         n_fail++;
         $display("FAIL basic_counts: pops=%0d outputs=%0d required 5 and 5",
                  pop_cyc.size(), out_cyc.size());
      end else begin
         n_checks++;
         if (pop_cyc[0] != start + 1) begin
            n_fail++;
            $display("FAIL basic_first_pop: cycle %0d required %0d", pop_cyc[0] - start, 1);
         end
         n_checks++;
         if (out_cyc[0] != pop_cyc[0] + 2) begin
            n_fail++;
            $display("FAIL basic_latency: valid %0d cycles after pop required 2",
                     out_cyc[0] - pop_cyc[0]);
         end
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
               n_fail++;
               $display("FAIL basic_out%0d: data=%0d primed=%b required data=%0d primed=%b",
                        i, got_d[i], got_p[i], exp_d[i], exp_p[i]);
            end
            if (i > 0) begin
               n_checks++;
               if (pop_cyc[i] - pop_cyc[i-1] != 3) begin
                  n_fail++;
                  $display("FAIL basic_pop_spacing%0d: got %0d required 3",
                           i, pop_cyc[i] - pop_cyc[i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int unstable = 0;
      pulse_clear();
      push(8'd10); push(8'd20); push(8'd30); push(8'd40);
      expect_out(8'd2, 1'b0, "bp_out0");
      expect_out(8'd7, 1'b0, "bp_out1");
      wait_valid("bp_out2");
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_valid !== 1'b1 || o_data !== 8'd15 || o_r_inc !== 1'b0 || o_primed !== 1'b0)
            unstable++;
      end
      n_checks++;
      if (unstable != 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d unstable cycles required 0 (data=%0d)", unstable, o_data);
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      n_checks++;
      if (o_r_inc !== 1'b1 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: r_inc=%b valid=%b required r_inc=1 valid=0", o_r_inc, o_valid);
      end
      expect_out(8'd25, 1'b1, "bp_out3");
   endtask

   task automatic test_clear_in_pop();
      int n = 0;
      int leaked = 0;
      push(8'd99);
      while (o_r_inc !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      n_checks++;
      if (o_r_inc !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_pop_seen: r_inc=%b required 1", o_r_inc);
      end
      pulse_clear();
      n_checks++;
      if (q.size() != 0 || o_valid !== 1'b0 || o_primed !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_after: fifo_left=%0d valid=%b primed=%b required 0 0 0",
                  q.size(), o_valid, o_primed);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (o_valid !== 1'b0 || o_r_inc !== 1'b0) leaked++;
      end
      n_checks++;
      if (leaked != 0) begin
         n_fail++;
         $display("FAIL clr_discard: %0d active cycles required 0", leaked);
      end
      push(8'd8);
      expect_out(8'd2, 1'b0, "clr_next");
   endtask

   task automatic test_underflow();
      int active = 0;
      pulse_clear();
      push(8'd10); push(8'd20);
      expect_out(8'd2, 1'b0, "uf_out0");
      expect_out(8'd7, 1'b0, "uf_out1");
      for (int i = 0; i < 8; i++) begin
         tick();
         if (o_r_inc !== 1'b0 || o_valid !== 1'b0) active++;
      end
      n_checks++;
      if (active != 0) begin
         n_fail++;
         $display("FAIL uf_idle: %0d active cycles while empty required 0", active);
      end
      push(8'd30);
      expect_out(8'd15, 1'b0, "uf_resume");
   endtask

   task automatic test_async_reset();
      push(8'd40);
      wait_valid("ar_out");
      n_checks++;
      if (o_data !== 8'd25 || o_primed !== 1'b1) begin
         n_fail++;
         $display("FAIL ar_before: data=%0d primed=%b required 25 1", o_data, o_primed);
      end
      #2;
      i_rstn = 1'b0;
      #1;
      n_checks++;
      if (o_valid !== 1'b0 || o_data !== 8'd0 || o_primed !== 1'b0 || o_r_inc !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_immediate: valid=%b data=%0d primed=%b r_inc=%b required all 0",
                  o_valid, o_data, o_primed, o_r_inc);
      end
      tick();
      tick();
      i_rstn = 1'b1;
   endtask

   task automatic test_full_scale();
      push(8'd255); push(8'd255); push(8'd255); push(8'd255);
      expect_out(8'd63,  1'b0, "fs_out0");
      expect_out(8'd127, 1'b0, "fs_out1");
      expect_out(8'd191, 1'b0, "fs_out2");
      expect_out(8'd255, 1'b1, "fs_out3");
   endtask

   initial begin
      sync_fifo();
      test_reset();
      test_basic_stream();
      test_backpressure();
      test_clear_in_pop();
      test_underflow();
      test_async_reset();
      test_full_scale();
      n_checks++;
      if (bad_pop != 0) begin
         n_fail++;
         $display("FAIL pop_while_empty: got %0d required 0", bad_pop);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
